// File: rtl/isp_uart_rx_pkg.sv
// Shared definitions for the ISP UART receiver: FSM state encoding,
// oversampling constants and the LSB-first shift helper.
package isp_uart_pkg;

  localparam int OVS_RATE     = 16;
  localparam int SAMPLE_PHASE = 8;
  localparam int DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_e;

  // Serial data arrives LSB first, so each new bit enters at the top.
  function automatic logic [7:0] shift_in(input logic [7:0] sr, input logic bit_in);
    return {bit_in, sr[7:1]};
  endfunction

endpackage

// File: rtl/isp_uart_rx_fifo.sv
// Single-clock first-word-fall-through FIFO. A pop is evaluated before a push,
// so a push into a full FIFO is accepted when a pop happens in the same cycle.
module isp_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LVL_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   LVL_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = LVL_ONE[AW-1:0];

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      level_r;
  logic [AW:0]      level_nxt_s;
  logic             empty_r;
  logic             full_s;
  logic             pop_s;
  logic             push_s;

  // Pop/push qualification and next occupancy.
  always_comb begin
    full_s      = (level_r == LVL_FULL);
    pop_s       = rd_en & ~empty_r;
    push_s      = wr_en & (~full_s | pop_s);
    level_nxt_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_ONE;
      2'b01:   level_nxt_s = level_r - LVL_ONE;
      default: level_nxt_s = level_r;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LVL_ZERO;
      empty_r  <= 1'b1;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      level_r <= level_nxt_s;
      empty_r <= (level_nxt_s == LVL_ZERO);
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= wr_data;
  end

  // Head byte is forced to zero while empty so reset leaves a clean output.
  always_comb begin
    if (empty_r) begin
      rd_data = {WIDTH{1'b0}};
    end else begin
      rd_data = mem_r[rd_ptr_r];
    end
  end

  assign full  = full_s;
  assign empty = empty_r;
  assign level = level_r;

endmodule

// File: rtl/isp_uart_rx.sv
// 8N1 UART receiver with 16x oversampling, sticky frame/overrun flags and a
// first-word-fall-through receive FIFO.
module isp_uart_rx
  import isp_uart_pkg::*;
#(
  parameter int OVS_DIV    = 27,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          CLK_BASE,
  input  logic                          FAB_RESET,
  input  logic                          UART_RXD,
  output logic [7:0]                    RX_DATA,
  output logic                          RX_VALID,
  input  logic                          RX_READY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic                          FRAME_ERR,
  output logic                          OVERRUN,
  input  logic                          ERR_CLR
);

  localparam int DIV_W = $clog2(OVS_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_ZERO    = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(OVS_DIV - 1);
  localparam logic [3:0]       TICK_ZERO   = 4'd0;
  localparam logic [3:0]       TICK_ONE    = 4'd1;
  localparam logic [3:0]       TICK_START  = 4'(SAMPLE_PHASE - 1);
  localparam logic [3:0]       TICK_CENTRE = 4'(OVS_RATE - 1);
  localparam logic [2:0]       BIT_ZERO    = 3'd0;
  localparam logic [2:0]       BIT_ONE     = 3'd1;
  localparam logic [2:0]       BIT_LAST    = 3'(DATA_BITS - 1);

  logic             rxd_meta_r;
  logic             rxd_sync_r;
  logic             rxd_prev_r;
  logic [1:0]       warm_r;
  logic             armed_r;
  logic [DIV_W-1:0] div_r;
  logic             tick_s;
  logic             fall_s;

  rx_state_e        state_r;
  rx_state_e        state_nxt_s;
  logic [3:0]       tick_cnt_r;
  logic [3:0]       tick_cnt_nxt_s;
  logic [2:0]       bit_cnt_r;
  logic [2:0]       bit_cnt_nxt_s;
  logic [7:0]       shift_r;
  logic [7:0]       shift_nxt_s;
  logic             push_s;
  logic             ferr_evt_s;
  logic             div_clr_s;
  logic             drop_s;

  logic             frame_err_r;
  logic             overrun_r;
  logic             fifo_full_s;
  logic             fifo_empty_s;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge CLK_BASE) begin
    if (FAB_RESET) begin
      rxd_meta_r <= 1'b1;
      rxd_sync_r <= 1'b1;
      rxd_prev_r <= 1'b1;
    end else begin
      rxd_meta_r <= UART_RXD;
      rxd_sync_r <= rxd_meta_r;
      rxd_prev_r <= rxd_sync_r;
    end
  end

  // After reset the line must be seen genuinely high before a start edge counts,
  // so a frame already in flight at reset release is ignored.
  always_ff @(posedge CLK_BASE) begin
    if (FAB_RESET) begin
      warm_r  <= 2'b00;
      armed_r <= 1'b0;
    end else begin
      warm_r <= {warm_r[0], 1'b1};
      if (warm_r[1] & rxd_sync_r) armed_r <= 1'b1;
    end
  end

  assign fall_s = armed_r & rxd_prev_r & ~rxd_sync_r;
  assign tick_s = (div_r == DIV_LAST);

  // Oversample tick divider, realigned to the start edge.
  always_ff @(posedge CLK_BASE) begin
    if (FAB_RESET) begin
      div_r <= DIV_ZERO;
    end else if (div_clr_s || tick_s) begin
      div_r <= DIV_ZERO;
    end else begin
      div_r <= div_r + DIV_ONE;
    end
  end

  // Receive FSM next-state and datapath decisions.
  always_comb begin
    state_nxt_s    = state_r;
    tick_cnt_nxt_s = tick_cnt_r;
    bit_cnt_nxt_s  = bit_cnt_r;
    shift_nxt_s    = shift_r;
    push_s         = 1'b0;
    ferr_evt_s     = 1'b0;
    div_clr_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (fall_s) begin
          state_nxt_s    = START;
          tick_cnt_nxt_s = TICK_ZERO;
          bit_cnt_nxt_s  = BIT_ZERO;
          div_clr_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (tick_s && (tick_cnt_r == TICK_START)) begin
          tick_cnt_nxt_s = TICK_ZERO;
          if (!rxd_sync_r) begin
            state_nxt_s = DATA;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (tick_s) begin
          tick_cnt_nxt_s = tick_cnt_r + TICK_ONE;
        end else begin
          tick_cnt_nxt_s = tick_cnt_r;
        end
      end
      DATA: begin
        if (tick_s && (tick_cnt_r == TICK_CENTRE)) begin
          tick_cnt_nxt_s = TICK_ZERO;
          shift_nxt_s    = shift_in(shift_r, rxd_sync_r);
          if (bit_cnt_r == BIT_LAST) begin
            bit_cnt_nxt_s = BIT_ZERO;
            state_nxt_s   = STOP;
          end else begin
            bit_cnt_nxt_s = bit_cnt_r + BIT_ONE;
          end
        end else if (tick_s) begin
          tick_cnt_nxt_s = tick_cnt_r + TICK_ONE;
        end else begin
          tick_cnt_nxt_s = tick_cnt_r;
        end
      end
      STOP: begin
        if (tick_s && (tick_cnt_r == TICK_CENTRE)) begin
          tick_cnt_nxt_s = TICK_ZERO;
          if (rxd_sync_r) begin
            push_s      = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            ferr_evt_s  = 1'b1;
            state_nxt_s = WAIT_IDLE;
          end
        end else if (tick_s) begin
          tick_cnt_nxt_s = tick_cnt_r + TICK_ONE;
        end else begin
          tick_cnt_nxt_s = tick_cnt_r;
        end
      end
      WAIT_IDLE: begin
        if (rxd_sync_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM and shift register state.
  always_ff @(posedge CLK_BASE) begin
    if (FAB_RESET) begin
      state_r    <= IDLE;
      tick_cnt_r <= TICK_ZERO;
      bit_cnt_r  <= BIT_ZERO;
      shift_r    <= 8'h00;
    end else begin
      state_r    <= state_nxt_s;
      tick_cnt_r <= tick_cnt_nxt_s;
      bit_cnt_r  <= bit_cnt_nxt_s;
      shift_r    <= shift_nxt_s;
    end
  end

  assign drop_s = push_s & fifo_full_s & ~(RX_READY & ~fifo_empty_s);

  // Sticky error flags; a new event outranks a clear in the same cycle.
  always_ff @(posedge CLK_BASE) begin
    if (FAB_RESET) begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= ferr_evt_s | (frame_err_r & ~ERR_CLR);
      overrun_r   <= drop_s | (overrun_r & ~ERR_CLR);
    end
  end

  isp_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK_BASE),
    .rst     (FAB_RESET),
    .wr_en   (push_s),
    .wr_data (shift_r),
    .rd_en   (RX_READY),
    .rd_data (RX_DATA),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .level   (FIFO_LEVEL)
  );

  assign RX_VALID  = ~fifo_empty_s;
  assign FRAME_ERR = frame_err_r;
  assign OVERRUN   = overrun_r;

endmodule
